// File: rtl/input_conditioner.sv
// Synchronises, debounces and edge-decodes the push button and DIP switches
// feeding the flowing-lights LED shifter.
module input_conditioner #(
  parameter logic [31:0] DEBOUNCE_CNT = 32'd2000000,
  parameter logic [31:0] LONG_CNT     = 32'd100000000,
  parameter int          SW_W         = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            button,
  input  logic [SW_W-1:0] sw_in,
  output logic            btn_level,
  output logic            press_pulse,
  output logic            release_pulse,
  output logic            long_pulse,
  output logic [SW_W-1:0] sw_stable,
  output logic            sw_change
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;

  localparam logic [31:0] DB_LAST   = DEBOUNCE_CNT - 32'd1;
  localparam logic [31:0] LONG_LAST = LONG_CNT - 32'd1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

  logic            btn_meta_p0, btn_sync_p1;
  logic [SW_W-1:0] sw_meta_p0, sw_sync_p1;

  btn_state_t  state_p2, state_nxt;
  logic [31:0] dcnt_p2, dcnt_nxt, hcnt_p2, hcnt_nxt;
  logic        long_flag_p2, long_flag_nxt;
  logic        press_evt_p2, release_evt_p2, long_evt_p2;
  logic        press_c, release_c, long_c, level_c;

  logic [SW_W-1:0] sw_prev_p2, sw_ref_p2;
  logic [31:0]     scnt_p2;
  logic            sw_evt_p2;

  // Stage p0/p1: two-flop synchronisers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_p0 <= 1'b0;
      btn_sync_p1 <= 1'b0;
      sw_meta_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      btn_meta_p0 <= button;
      btn_sync_p1 <= btn_meta_p0;
      sw_meta_p0  <= sw_in;
      sw_sync_p1  <= sw_meta_p0;
    end
  end

  // Stage p2: button FSM state and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p2       <= IDLE;
      dcnt_p2        <= '0;
      hcnt_p2        <= '0;
      long_flag_p2   <= 1'b0;
      press_evt_p2   <= 1'b0;
      release_evt_p2 <= 1'b0;
      long_evt_p2    <= 1'b0;
    end else begin
      state_p2       <= state_nxt;
      dcnt_p2        <= dcnt_nxt;
      hcnt_p2        <= hcnt_nxt;
      long_flag_p2   <= long_flag_nxt;
      press_evt_p2   <= press_c;
      release_evt_p2 <= release_c;
      long_evt_p2    <= long_c;
    end
  end

  always_comb begin
    state_nxt     = state_p2;
    dcnt_nxt      = dcnt_p2;
    hcnt_nxt      = hcnt_p2;
    long_flag_nxt = long_flag_p2;
    unique case (state_p2)
      IDLE: begin
        if (btn_sync_p1) begin
          state_nxt = PRESS_WAIT;
          dcnt_nxt  = 32'd1;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync_p1) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else if (dcnt_p2 == DB_LAST) begin
          state_nxt     = HELD;
          dcnt_nxt      = '0;
          hcnt_nxt      = '0;
          long_flag_nxt = 1'b0;
        end else begin
          dcnt_nxt = dcnt_p2 + 32'd1;
        end
      end
      HELD: begin
        hcnt_nxt      = sat_inc(hcnt_p2, LONG_CNT);
        long_flag_nxt = long_flag_p2 | long_c;
        if (!btn_sync_p1) begin
          state_nxt = RELEASE_WAIT;
          dcnt_nxt  = 32'd1;
        end
      end
      RELEASE_WAIT: begin
        hcnt_nxt      = sat_inc(hcnt_p2, LONG_CNT);
        long_flag_nxt = long_flag_p2 | long_c;
        // A bounce back to high resumes the hold without a new press
        if (btn_sync_p1) begin
          state_nxt = HELD;
          dcnt_nxt  = '0;
        end else if (dcnt_p2 == DB_LAST) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt = dcnt_p2 + 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level_c   = (state_p2 == HELD) || (state_p2 == RELEASE_WAIT);
    press_c   = (state_p2 == PRESS_WAIT) && btn_sync_p1 && (dcnt_p2 == DB_LAST);
    release_c = (state_p2 == RELEASE_WAIT) && !btn_sync_p1 && (dcnt_p2 == DB_LAST);
    long_c    = level_c && (hcnt_p2 == LONG_LAST) && !long_flag_p2;
  end

  // Stage p2: shared switch debounce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_prev_p2 <= '0;
      sw_ref_p2  <= '0;
      scnt_p2    <= '0;
      sw_evt_p2  <= 1'b0;
    end else begin
      sw_prev_p2 <= sw_sync_p1;
      sw_evt_p2  <= 1'b0;
      if (sw_sync_p1 == sw_ref_p2) begin
        scnt_p2 <= '0;
      end else if (sw_sync_p1 != sw_prev_p2) begin
        scnt_p2 <= 32'd1;
      end else if (scnt_p2 == DB_LAST) begin
        sw_ref_p2 <= sw_sync_p1;
        sw_evt_p2 <= 1'b1;
        scnt_p2   <= '0;
      end else begin
        scnt_p2 <= scnt_p2 + 32'd1;
      end
    end
  end

  // Stage p3: output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      sw_stable     <= '0;
      sw_change     <= 1'b0;
    end else begin
      btn_level     <= level_c;
      press_pulse   <= press_evt_p2;
      release_pulse <= release_evt_p2;
      long_pulse    <= long_evt_p2;
      sw_stable     <= sw_ref_p2;
      sw_change     <= sw_evt_p2;
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CNT=4, LONG_CNT=20.
module tb_input_conditioner;
  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [2:0] sw_in;
  logic       btn_level, press_pulse, release_pulse, long_pulse, sw_change;
  logic [2:0] sw_stable;

  input_conditioner #(
    .DEBOUNCE_CNT(32'd4),
    .LONG_CNT    (32'd20),
    .SW_W        (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .sw_in        (sw_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .sw_stable    (sw_stable),
    .sw_change    (sw_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       rst_v;
    logic       btn;
    logic [2:0] sw;
    logic [7:0] exp;  // {btn_level, press, release, long, sw_stable[2:0], sw_change}
  } vec_t;

  vec_t tbl[11];

  int nchk = 0;
  int nerr = 0;
  int cyc;
  int np, fp, nr, fr, nl, fl, nc, fc, nlvl, nboth;

  function automatic logic [7:0] outs();
    return {btn_level, press_pulse, release_pulse, long_pulse, sw_stable, sw_change};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; np = 0; fp = -1; nr = 0; fr = -1; nl = 0; fl = -1;
    nc = 0; fc = -1; nlvl = 0; nboth = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (press_pulse)   begin np++; if (fp < 0) fp = cyc; end
    if (release_pulse) begin nr++; if (fr < 0) fr = cyc; end
    if (long_pulse)    begin nl++; if (fl < 0) fl = cyc; end
    if (sw_change)     begin nc++; if (fc < 0) fc = cyc; end
    if (btn_level) nlvl++;
    if (press_pulse && release_pulse) nboth++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    // Clean press with power-up switches at 011; button falls after edge 30
    tbl[0]  = '{0,  1'b0, 1'b1, 3'b011, 8'h00};
    tbl[1]  = '{6,  1'b0, 1'b1, 3'b011, 8'h00};
    tbl[2]  = '{7,  1'b0, 1'b1, 3'b011, 8'hC7};
    tbl[3]  = '{8,  1'b0, 1'b1, 3'b011, 8'h86};
    tbl[4]  = '{26, 1'b0, 1'b1, 3'b011, 8'h86};
    tbl[5]  = '{27, 1'b0, 1'b1, 3'b011, 8'h96};
    tbl[6]  = '{28, 1'b0, 1'b1, 3'b011, 8'h86};
    tbl[7]  = '{30, 1'b0, 1'b0, 3'b011, 8'h86};
    tbl[8]  = '{36, 1'b0, 1'b0, 3'b011, 8'h86};
    tbl[9]  = '{37, 1'b0, 1'b0, 3'b011, 8'h26};
    tbl[10] = '{38, 1'b0, 1'b0, 3'b011, 8'h06};

    rst = 1'b1; button = 1'b0; sw_in = 3'b011;
    steps(3);
    clear_obs();
    for (int i = 0; i < 11; i++) begin
      while (cyc < tbl[i].cyc) step();
      check($sformatf("vec%0d_edge%0d", i, tbl[i].cyc), {24'd0, outs()}, {24'd0, tbl[i].exp});
      rst = tbl[i].rst_v; button = tbl[i].btn; sw_in = tbl[i].sw;
    end
    check("t1_press_count", np, 1);
    check("t1_long_count", nl, 1);
    check("t1_release_count", nr, 1);
    check("t5_change_count", nc, 1);
    check("t1_level_cycles", nlvl, 30);

    // Glitch: two cycles high must not be accepted
    steps(5);
    clear_obs();
    button = 1'b1; steps(2);
    button = 1'b0; steps(12);
    check("t2_glitch_press", np, 0);
    check("t2_glitch_level", nlvl, 0);

    // Release bounce while held
    clear_obs();
    button = 1'b1; steps(10);
    button = 1'b0; steps(2);
    button = 1'b1; steps(28);
    button = 1'b0; steps(15);
    check("t3_press_edge", fp, 7);
    check("t3_press_count", np, 1);
    check("t3_long_edge", fl, 27);
    check("t3_long_count", nl, 1);
    check("t3_release_edge", fr, 47);
    check("t3_release_count", nr, 1);
    check("t3_level_cycles", nlvl, 40);

    // Switch change with a one-cycle bounce, then a toggle-back
    sw_in = 3'b000; steps(12);
    check("t4_sw_zero", sw_stable, 3'b000);
    clear_obs();
    sw_in = 3'b101; steps(2);
    sw_in = 3'b100; steps(1);
    sw_in = 3'b101; steps(12);
    check("t4_change_edge", fc, 10);
    check("t4_change_count", nc, 1);
    check("t4_sw_stable", sw_stable, 3'b101);
    clear_obs();
    sw_in = 3'b111; steps(2);
    sw_in = 3'b101; steps(12);
    check("t4_toggle_back_count", nc, 0);
    check("t4_toggle_back_stable", sw_stable, 3'b101);

    // Reset while held (hcnt=10), button kept high
    clear_obs();
    button = 1'b1; steps(16);
    check("t6_level_before_rst", btn_level, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_outs_async_rst", {24'd0, outs()}, 32'd0);
    steps(2);
    check("t6_outs_in_rst", {24'd0, outs()}, 32'd0);
    rst = 1'b0;
    clear_obs();
    steps(12);
    check("t6_press_edge", fp, 7);
    check("t6_press_count", np, 1);
    check("t6_change_edge", fc, 7);
    check("t6_long_count", nl, 0);
    check("t6_sw_stable", sw_stable, 3'b101);
    check("press_release_overlap", nboth, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
